// File: rtl/dpll_trim_controller.sv
// Frequency-locking trim controller for ring_osc2x13, clocked by the oscillator itself.
// Latency: ref edge -> rise pulse 2-3 clocks; rise -> meas/tval/locked update 1 clock.
// Backpressure: none; one measurement per reference period, always accepted.
//
// Ports:
//   clock      oscillator clock (clockp[0]), the only clock
//   reset      synchronous active-high reset
//   enable     loop enable; low freezes trim and clears lock/priming
//   ref_clk    asynchronous reference clock, sampled as data
//   div        target oscillator cycles per reference period
//   trim       thermometer trim, trim[i] = (i < tval)
//   tval       current tap count, 0..TRIM_W
//   meas       last measured period in oscillator cycles
//   meas_valid one-cycle pulse when meas/tval/locked update
//   locked     LOCK_N consecutive in-band measurements seen
module dpll_trim_controller #(
    parameter int TRIM_W    = 26,
    parameter int CNT_W     = 6,
    parameter int TRIM_INIT = 13,
    parameter int TOL       = 0,
    parameter int LOCK_N    = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              ref_clk,
    input  logic [CNT_W-1:0]  div,
    output logic [TRIM_W-1:0] trim,
    output logic [4:0]        tval,
    output logic [CNT_W-1:0]  meas,
    output logic              meas_valid,
    output logic              locked
);

    localparam int LK_W = $clog2(LOCK_N + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W:0]   TOL_X   = (CNT_W + 1)'(TOL);
    localparam logic [4:0]       TV_MAX  = 5'(TRIM_W);
    localparam logic [4:0]       TV_INIT = 5'(TRIM_INIT);
    localparam logic [LK_W-1:0]  LK_MAX  = LK_W'(LOCK_N);

    logic             s1, s2, s3;
    logic             rise;
    logic             primed;
    logic [CNT_W-1:0] cnt;
    logic [LK_W-1:0]  lock_cnt;

    logic             too_fast, too_slow;
    logic [4:0]       tval_nxt;
    logic [LK_W-1:0]  lock_nxt;

    assign rise = s2 & ~s3;

    // Comparisons are done one bit wider so div+TOL and cnt+TOL cannot wrap.
    always_comb begin
        too_fast = ({1'b0, cnt} > ({1'b0, div} + TOL_X));
        too_slow = (({1'b0, cnt} + TOL_X) < {1'b0, div});

        tval_nxt = tval;
        if (too_fast) begin
            if (tval != TV_MAX) tval_nxt = tval + 5'd1;
        end else if (too_slow) begin
            if (tval != 5'd0) tval_nxt = tval - 5'd1;
        end

        lock_nxt = '0;
        if (!too_fast && !too_slow) begin
            lock_nxt = (lock_cnt == LK_MAX) ? LK_MAX : lock_cnt + LK_W'(1);
        end
    end

    // Thermometer decode straight off the tval register.
    always_comb begin
        trim = '0;
        for (int i = 0; i < TRIM_W; i++) begin
            trim[i] = (5'(i) < tval);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            primed     <= 1'b0;
            tval       <= TV_INIT;
            meas       <= '0;
            meas_valid <= 1'b0;
            lock_cnt   <= '0;
            locked     <= 1'b0;
        end else begin
            s1         <= ref_clk;
            s2         <= s1;
            s3         <= s2;
            meas_valid <= 1'b0;
            if (!enable) begin
                cnt      <= '0;
                primed   <= 1'b0;
                lock_cnt <= '0;
                locked   <= 1'b0;
            end else begin
                // Saturating period counter; a missing ref reads as CNT_MAX (too fast).
                if (rise) begin
                    cnt <= CNT_W'(1);
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (rise) begin
                    if (!primed) begin
                        // First rise only starts the count; no valid period yet.
                        primed <= 1'b1;
                    end else begin
                        meas       <= cnt;
                        meas_valid <= 1'b1;
                        tval       <= tval_nxt;
                        lock_cnt   <= lock_nxt;
                        locked     <= (lock_nxt == LK_MAX);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dpll_trim_controller.sv
// Directed bench for dpll_trim_controller with hand-computed expectations.
// Latency: checks land #1 after the active clock edge; pulses are logged on negedge.
// Backpressure: n/a.
module tb_dpll_trim_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        ref_clk;
    logic [5:0]  div;
    logic [25:0] trim;
    logic [4:0]  tval;
    logic [5:0]  meas;
    logic        meas_valid;
    logic        locked;

    int n_cmp = 0;
    int n_err = 0;

    int          mv_count = 0;
    logic [5:0]  last_meas;
    logic [4:0]  last_tval;
    logic        last_locked;
    int          mv_base;
    int          exp_tv;

    dpll_trim_controller dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .ref_clk    (ref_clk),
        .div        (div),
        .trim       (trim),
        .tval       (tval),
        .meas       (meas),
        .meas_valid (meas_valid),
        .locked     (locked)
    );

    always #5 clock = ~clock;

    // Log every measurement pulse together with the values that arrive with it.
    always @(negedge clock) begin
        if (meas_valid) begin
            mv_count    <= mv_count + 1;
            last_meas   <= meas;
            last_tval   <= tval;
            last_locked <= locked;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // One reference period of p clocks, starting with a rising edge.
    task automatic run_period(input int p);
        ref_clk = 1'b1;
        tick(p / 2);
        ref_clk = 1'b0;
        tick(p - p / 2);
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        ref_clk = 1'b0;
        tick(3);
        reset   = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        enable  = 1'b1;
        ref_clk = 1'b0;
        div     = 6'd8;
        tick(1);

        // Reset with ref toggling: state stays at reset values, no pulses.
        mv_base = mv_count;
        for (int i = 0; i < 6; i++) begin
            ref_clk = ~ref_clk;
            tick(2);
            chk("rst_mv", {31'd0, meas_valid}, 32'd0);
        end
        do_reset();
        chk("rst_tval",   {27'd0, tval}, 32'd13);
        chk("rst_trim",   {6'd0, trim}, 32'h0001FFF);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_meas",   {26'd0, meas}, 32'd0);
        chk("rst_pulses", mv_count - mv_base, 32'd0);

        // Too fast: period 10 vs div 8 -> climb to 26 and saturate.
        mv_base = mv_count;
        run_period(10);
        chk("fast_prime", mv_count - mv_base, 32'd0);
        for (int i = 1; i <= 15; i++) begin
            run_period(10);
            exp_tv = (13 + i > 26) ? 26 : 13 + i;
            chk("fast_meas", {26'd0, last_meas}, 32'd10);
            chk("fast_tval", {27'd0, last_tval}, exp_tv);
        end
        chk("fast_pulses", mv_count - mv_base, 32'd15);
        chk("fast_trim",   {6'd0, trim}, 32'h3FFFFFF);
        chk("fast_locked", {31'd0, locked}, 32'd0);

        // Too slow: period 6 -> descend to 0 and hold.
        do_reset();
        run_period(6);
        for (int i = 1; i <= 15; i++) begin
            run_period(6);
            exp_tv = (13 - i < 0) ? 0 : 13 - i;
            chk("slow_meas", {26'd0, last_meas}, 32'd6);
            chk("slow_tval", {27'd0, last_tval}, exp_tv);
        end
        chk("slow_trim", {6'd0, trim}, 32'h0000000);

        // In band: lock on the 4th measurement, then lose it on a period of 10.
        do_reset();
        run_period(8);
        for (int i = 1; i <= 3; i++) begin
            run_period(8);
            chk("lock_pre", {31'd0, last_locked}, 32'd0);
            chk("lock_tval", {27'd0, last_tval}, 32'd13);
        end
        run_period(10);
        chk("lock_set",  {31'd0, last_locked}, 32'd1);
        chk("lock_meas", {26'd0, last_meas}, 32'd8);
        run_period(10);
        chk("unlock_locked", {31'd0, last_locked}, 32'd0);
        chk("unlock_tval",   {27'd0, last_tval}, 32'd14);
        chk("unlock_meas",   {26'd0, last_meas}, 32'd10);

        // Missing reference: counter saturates, then measured as 63 (too fast).
        do_reset();
        run_period(10);
        run_period(10);
        chk("miss_tval0", {27'd0, last_tval}, 32'd14);
        mv_base = mv_count;
        tick(100);
        chk("miss_nopulse", mv_count - mv_base, 32'd0);
        chk("miss_cnt",     {26'd0, dut.cnt}, 32'd63);
        run_period(10);
        chk("miss_meas", {26'd0, last_meas}, 32'd63);
        chk("miss_tval", {27'd0, last_tval}, 32'd15);

        // Mid-period reset at tval=20.
        do_reset();
        for (int i = 0; i < 8; i++) run_period(10);
        chk("mrst_pre", {27'd0, tval}, 32'd20);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("mrst_tval", {27'd0, tval}, 32'd13);
        mv_base = mv_count;
        run_period(10);
        chk("mrst_prime", mv_count - mv_base, 32'd0);
        run_period(10);
        chk("mrst_tval2", {27'd0, last_tval}, 32'd14);

        // Enable low for 50 cycles at tval=20.
        do_reset();
        for (int i = 0; i < 8; i++) run_period(10);
        enable  = 1'b0;
        mv_base = mv_count;
        for (int i = 0; i < 5; i++) run_period(10);
        chk("dis_nopulse", mv_count - mv_base, 32'd0);
        chk("dis_tval",    {27'd0, tval}, 32'd20);
        chk("dis_locked",  {31'd0, locked}, 32'd0);
        enable = 1'b1;
        run_period(10);
        chk("en_prime", mv_count - mv_base, 32'd0);
        chk("en_tval",  {27'd0, tval}, 32'd20);
        run_period(10);
        chk("en_tval2", {27'd0, last_tval}, 32'd21);
        chk("en_meas",  {26'd0, last_meas}, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
